// File: rtl/des_round_ctrl.sv
// des_round_ctrl
// Sequencing controller for the iterative DES round datapath: accepts a start
// request, loads the block and key, steps NUM_ROUNDS rounds supplying the round
// number and key-schedule rotate control, loads the output register and pulses
// done.
// Optional feature macro: DES_ROUND_STALL_EN adds the stall input, which
// freezes round progress while asserted in the ROUND state.
module des_round_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       decrypt,
`ifdef DES_ROUND_STALL_EN
    input  logic       stall,
`endif
    output logic       busy,
    output logic       load_data,
    output logic       load_key,
    output logic       round_en,
    output logic [3:0] round_num,
    output logic [1:0] shift_amt,
    output logic       shift_left,
    output logic       out_load,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state;
    state_t     nxt_state;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic       mode;
    logic       nxt_mode;
    logic       nxt_active;
    logic       frozen;

    // A ROUND cycle without round_en is a stalled cycle: the round it shows
    // has not executed yet, so the counter must not advance past it.
    assign frozen = (state == ROUND) && !round_en;

    // Key-schedule rotate amount per round; decrypt skips the round-0 rotate
    // because it walks the schedule backwards from the final C/D value.
    function automatic logic [1:0] shift_for(input logic [3:0] rnd, input logic dec);
        logic [1:0] amt;
        case (rnd)
            4'd0:              amt = dec ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: amt = 2'd1;
            default:           amt = 2'd2;
        endcase
        return amt;
    endfunction

    // Next state, counter, captured mode and whether the next cycle executes a round.
    // A start seen in the DONE cycle is accepted directly so a held start
    // yields back-to-back blocks every NUM_ROUNDS+3 cycles.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_mode   = mode;
        nxt_active = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = LOAD;
                    nxt_mode  = decrypt;
                end
            end
            LOAD: begin
                nxt_state = ROUND;
                nxt_cnt   = 4'd0;
            end
            ROUND: begin
                if (!frozen) begin
                    if (cnt == LAST_ROUND) begin
                        nxt_state = FINAL;
                    end else begin
                        nxt_cnt = cnt + 4'd1;
                    end
                end
            end
            FINAL: begin
                nxt_state = DONE;
            end
            DONE: begin
                if (start) begin
                    nxt_state = LOAD;
                    nxt_mode  = decrypt;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
        nxt_active = (nxt_state == ROUND);
`ifdef DES_ROUND_STALL_EN
        if (stall && (state == ROUND) && (nxt_state == ROUND)) begin
            nxt_active = 1'b0;
        end
`endif
    end

    // State, counter, mode and registered Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            mode       <= 1'b0;
            busy       <= 1'b0;
            load_data  <= 1'b0;
            load_key   <= 1'b0;
            round_en   <= 1'b0;
            round_num  <= 4'd0;
            shift_amt  <= 2'd0;
            shift_left <= 1'b0;
            out_load   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            mode       <= nxt_mode;
            busy       <= (nxt_state != IDLE);
            load_data  <= (nxt_state == LOAD);
            load_key   <= (nxt_state == LOAD);
            round_en   <= nxt_active;
            round_num  <= (nxt_state == ROUND) ? nxt_cnt : 4'd0;
            shift_amt  <= nxt_active ? shift_for(nxt_cnt, nxt_mode) : 2'd0;
            shift_left <= (nxt_state == ROUND) && !nxt_mode;
            out_load   <= (nxt_state == FINAL);
            done       <= (nxt_state == DONE);
        end
    end

endmodule
